// File: rtl/mem_port_arbiter.sv
// Merges the instruction-fetch and data ports onto one single-port memory channel.
// One transaction in flight, round-robin on contention, watchdog-forced error response.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    // Instruction fetch port
    input  logic [31:0] i_addr,
    input  logic        i_addr_valid,
    output logic [31:0] i_rdata,
    output logic        i_rdata_valid,
    // Data port
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [7:0]  d_wmask,
    input  logic        d_wen,
    input  logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    // Memory channel
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic        m_wen,
    output logic [31:0] m_wdata,
    output logic [7:0]  m_wmask,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        err_timeout
);

    localparam logic [15:0] CntLimit = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] CntMax   = 16'hFFFF;

    typedef enum logic [2:0] {
        StIdle,
        StReqI,
        StReqD,
        StWaitI,
        StWaitD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic        m_wen_q, m_wen_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [7:0]  m_wmask_q, m_wmask_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_d_q, last_d_d;    // 1: data port won the last grant
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        i_valid_q, i_valid_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_ready_q, d_ready_d;
    logic        err_q, err_d;

    logic in_req, in_wait, serving_d;
    logic req_i, req_d, grant_i, grant_d;
    logic resp, expire;

    always_comb begin
        state_d   = state_q;
        m_addr_d  = m_addr_q;
        m_wen_d   = m_wen_q;
        m_wdata_d = m_wdata_q;
        m_wmask_d = m_wmask_q;
        cnt_d     = cnt_q;
        last_d_d  = last_d_q;
        i_rdata_d = i_rdata_q;
        i_valid_d = 1'b0;
        d_rdata_d = d_rdata_q;
        d_ready_d = 1'b0;
        err_d     = err_q;

        in_req    = (state_q == StReqI) || (state_q == StReqD);
        in_wait   = (state_q == StWaitI) || (state_q == StWaitD);
        serving_d = (state_q == StReqD) || (state_q == StWaitD);

        // A port completing this cycle still shows its valid; it must not win again.
        req_i   = i_addr_valid & ~i_valid_q;
        req_d   = d_valid & ~d_ready_q;
        grant_i = req_i & (~req_d | last_d_q);
        grant_d = req_d & ~grant_i;

        // Responses outside an accepted request are stale and dropped.
        resp   = m_rvalid & (in_wait | (in_req & m_gnt));
        expire = (in_req | in_wait) & (cnt_q == CntLimit);

        if (in_req || in_wait) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 16'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (grant_i) begin
                    m_addr_d  = i_addr;
                    m_wen_d   = 1'b0;
                    m_wdata_d = 32'd0;
                    m_wmask_d = 8'd0;
                    last_d_d  = 1'b0;
                    cnt_d     = 16'd0;
                    state_d   = StReqI;
                end else if (grant_d) begin
                    m_addr_d  = d_addr;
                    m_wen_d   = d_wen;
                    m_wdata_d = d_wdata;
                    m_wmask_d = d_wmask;
                    last_d_d  = 1'b1;
                    cnt_d     = 16'd0;
                    state_d   = StReqD;
                end
            end
            StReqI: begin
                if (m_gnt) state_d = StWaitI;
            end
            StReqD: begin
                if (m_gnt) state_d = StWaitD;
            end
            StWaitI, StWaitD: begin
            end
            default: state_d = StIdle;
        endcase

        if (resp || expire) begin
            state_d = StIdle;
            if (serving_d) begin
                d_ready_d = 1'b1;
                d_rdata_d = !resp ? ERR_RDATA : (m_wen_q ? 32'd0 : m_rdata);
            end else begin
                i_valid_d = 1'b1;
                i_rdata_d = resp ? m_rdata : ERR_RDATA;
            end
            if (!resp) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            m_addr_q  <= 32'd0;
            m_wen_q   <= 1'b0;
            m_wdata_q <= 32'd0;
            m_wmask_q <= 8'd0;
            cnt_q     <= 16'd0;
            last_d_q  <= 1'b1;
            i_rdata_q <= 32'd0;
            i_valid_q <= 1'b0;
            d_rdata_q <= 32'd0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_addr_q  <= m_addr_d;
            m_wen_q   <= m_wen_d;
            m_wdata_q <= m_wdata_d;
            m_wmask_q <= m_wmask_d;
            cnt_q     <= cnt_d;
            last_d_q  <= last_d_d;
            i_rdata_q <= i_rdata_d;
            i_valid_q <= i_valid_d;
            d_rdata_q <= d_rdata_d;
            d_ready_q <= d_ready_d;
            err_q     <= err_d;
        end
    end

    assign m_req         = (state_q == StReqI) || (state_q == StReqD);
    assign m_addr        = m_addr_q;
    assign m_wen         = m_wen_q;
    assign m_wdata       = m_wdata_q;
    assign m_wmask       = m_wmask_q;
    assign i_rdata       = i_rdata_q;
    assign i_rdata_valid = i_valid_q;
    assign d_rdata       = d_rdata_q;
    assign d_ready       = d_ready_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then randomized traffic against a
// transaction-level model of port selection, memory timing and response data.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic        i_addr_valid;
    logic [31:0] i_rdata;
    logic        i_rdata_valid;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [7:0]  d_wmask;
    logic        d_wen;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_wen;
    logic [31:0] m_wdata;
    logic [7:0]  m_wmask;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        err_timeout;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .ERR_RDATA     (32'hDEADBEEF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_addr       (i_addr),
        .i_addr_valid (i_addr_valid),
        .i_rdata      (i_rdata),
        .i_rdata_valid(i_rdata_valid),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_wmask      (d_wmask),
        .d_wen        (d_wen),
        .d_valid      (d_valid),
        .d_rdata      (d_rdata),
        .d_ready      (d_ready),
        .m_req        (m_req),
        .m_addr       (m_addr),
        .m_wen        (m_wen),
        .m_wdata      (m_wdata),
        .m_wmask      (m_wmask),
        .m_gnt        (m_gnt),
        .m_rvalid     (m_rvalid),
        .m_rdata      (m_rdata),
        .err_timeout  (err_timeout)
    );

    int checks   = 0;
    int failures = 0;
    bit pend_i, pend_d;
    bit last_d;     // model: port that received the most recent grant (1 = data)

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (m_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_rise", m_req, 32'd1);
    endtask

    task automatic raise_i();
        i_addr       = $urandom;
        i_addr_valid = 1'b1;
        pend_i       = 1'b1;
    endtask

    task automatic raise_d();
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_wmask = 8'($urandom);
        d_wen   = 1'($urandom);
        d_valid = 1'b1;
        pend_d  = 1'b1;
    endtask

    // Memory side: k cycles without grant (with stale rvalid noise), grant, then the
    // response d cycles later (d = 0: response together with the grant).
    task automatic serve(input int k, input int d, input bit scr, input bit port_d,
                         input logic [31:0] rd);
        logic [31:0] a0;
        a0 = m_addr;
        for (int j = 0; j < k; j++) begin
            chk("hold_req", m_req, 32'd1);
            chk("hold_addr", m_addr, a0);
            m_gnt    = 1'b0;
            m_rvalid = 1'($urandom);
            m_rdata  = ~rd;
            if (scr) begin
                if (port_d) begin
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                end else begin
                    i_addr = $urandom;
                end
            end
            tick();
        end
        chk("gnt_req", m_req, 32'd1);
        chk("gnt_addr", m_addr, a0);
        m_gnt    = 1'b1;
        m_rvalid = (d == 0);
        m_rdata  = rd;
        tick();
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        for (int j = 1; j <= d; j++) begin
            chk("wait_noreq", m_req, 32'd0);
            if (j == d) begin
                m_rvalid = 1'b1;
                m_rdata  = rd;
            end
            tick();
            m_rvalid = 1'b0;
        end
    endtask

    task automatic do_txn(input bit want_i, input bit want_d, input int k, input int d,
                          input bit scr);
        bit          p;
        logic [31:0] rd, ea, ew, em;
        logic        ewen;
        if (want_i && !pend_i) raise_i();
        if (want_d && !pend_d) raise_d();
        if (!pend_i && !pend_d) raise_i();
        p      = (pend_i && pend_d) ? !last_d : pend_d;
        last_d = p;
        if (p) begin
            ea   = d_addr;
            ewen = d_wen;
            ew   = d_wdata;
            em   = {24'd0, d_wmask};
        end else begin
            ea   = i_addr;
            ewen = 1'b0;
            ew   = 32'd0;
            em   = 32'd0;
        end
        wait_req();
        chk("m_addr", m_addr, ea);
        chk("m_wen", m_wen, ewen);
        chk("m_wmask", m_wmask, em);
        if (p) chk("m_wdata", m_wdata, ew);
        rd = $urandom;
        serve(k, d, scr, p, rd);
        chk("pulse_i", i_rdata_valid, !p);
        chk("pulse_d", d_ready, p);
        if (p) chk("d_rdata", d_rdata, ewen ? 32'd0 : rd);
        else   chk("i_rdata", i_rdata, rd);
        if (p) begin
            d_valid = 1'b0;
            pend_d  = 1'b0;
        end else begin
            i_addr_valid = 1'b0;
            pend_i       = 1'b0;
        end
        tick();
        chk("one_pulse_i", i_rdata_valid, 32'd0);
        chk("one_pulse_d", d_ready, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        i_addr       = 32'd0;
        i_addr_valid = 1'b0;
        d_addr       = 32'd0;
        d_wdata      = 32'd0;
        d_wmask      = 8'd0;
        d_wen        = 1'b0;
        d_valid      = 1'b0;
        m_gnt        = 1'b0;
        m_rvalid     = 1'b0;
        m_rdata      = 32'd0;
        pend_i       = 1'b0;
        pend_d       = 1'b0;
        last_d       = 1'b1;
        repeat (3) tick();

        chk("rst_m_req", m_req, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wen", m_wen, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_m_wmask", m_wmask, 32'd0);
        chk("rst_i_valid", i_rdata_valid, 32'd0);
        chk("rst_d_ready", d_ready, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_err", err_timeout, 32'd0);
        rst = 1'b0;

        // Fetch latency with m_gnt tied high: m_req cycle 1, pulse cycle 3
        m_gnt        = 1'b1;
        i_addr       = 32'h8000_0000;
        i_addr_valid = 1'b1;
        tick();
        chk("t1_req_c1", m_req, 32'd1);
        chk("t1_addr", m_addr, 32'h8000_0000);
        chk("t1_wmask", m_wmask, 32'd0);
        chk("t1_wen", m_wen, 32'd0);
        tick();
        chk("t1_req_c2", m_req, 32'd0);
        chk("t1_nopulse_c2", i_rdata_valid, 32'd0);
        m_rvalid = 1'b1;
        m_rdata  = 32'h0000_0013;
        tick();
        m_rvalid = 1'b0;
        m_gnt    = 1'b0;
        chk("t1_pulse_c3", i_rdata_valid, 32'd1);
        chk("t1_rdata", i_rdata, 32'h0000_0013);
        chk("t1_no_dready", d_ready, 32'd0);
        i_addr_valid = 1'b0;
        tick();
        chk("t1_pulse_c4", i_rdata_valid, 32'd0);
        chk("t1_no_dready_c4", d_ready, 32'd0);
        chk("t1_idle_c4", m_req, 32'd0);
        last_d = 1'b0;

        // Store pass-through
        d_addr  = 32'h8000_0100;
        d_wdata = 32'hA5A5_1234;
        d_wmask = 8'h0F;
        d_wen   = 1'b1;
        d_valid = 1'b1;
        pend_d  = 1'b1;
        do_txn(1'b0, 1'b0, 0, 1, 1'b0);

        // Contention from reset: I, D, I, D
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        last_d = 1'b1;
        for (int r = 0; r < 4; r++) do_txn(1'b1, 1'b1, 0, 1, 1'b0);

        // Grant withheld 5 cycles while the fetch inputs wander
        do_txn(1'b0, 1'b0, 5, 1, 1'b1);

        // Watchdog in REQ_I: pulse 8 cycles after entering REQ
        i_addr       = 32'h8000_0040;
        i_addr_valid = 1'b1;
        tick();
        for (int j = 1; j <= 8; j++) begin
            chk("t5_req_held", m_req, 32'd1);
            chk("t5_no_pulse", i_rdata_valid, 32'd0);
            chk("t5_err_low", err_timeout, 32'd0);
            tick();
        end
        chk("t5_pulse", i_rdata_valid, 32'd1);
        chk("t5_rdata", i_rdata, 32'hDEAD_BEEF);
        chk("t5_err", err_timeout, 32'd1);
        chk("t5_req_drop", m_req, 32'd0);
        i_addr_valid = 1'b0;
        m_rvalid     = 1'b1;
        m_rdata      = 32'h0000_1234;
        tick();
        m_rvalid = 1'b0;
        tick();
        chk("t5_late_ignored", i_rdata_valid, 32'd0);
        chk("t5_late_rdata", i_rdata, 32'hDEAD_BEEF);
        chk("t5_err_sticky", err_timeout, 32'd1);
        chk("t5_idle", m_req, 32'd0);
        last_d = 1'b0;

        // Watchdog in WAIT_D for a load
        d_addr  = 32'h8000_0200;
        d_wen   = 1'b0;
        d_wmask = 8'h00;
        d_valid = 1'b1;
        tick();
        chk("t5b_req", m_req, 32'd1);
        m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0;
        for (int j = 2; j <= 8; j++) begin
            chk("t5b_no_pulse", d_ready, 32'd0);
            tick();
        end
        chk("t5b_pulse", d_ready, 32'd1);
        chk("t5b_rdata", d_rdata, 32'hDEAD_BEEF);
        d_valid = 1'b0;
        tick();
        chk("t5b_one_pulse", d_ready, 32'd0);
        last_d = 1'b1;

        // Reset while in WAIT_D
        d_addr  = 32'h8000_0300;
        d_wen   = 1'b0;
        d_valid = 1'b1;
        tick();
        chk("t6_req", m_req, 32'd1);
        chk("t6_addr", m_addr, 32'h8000_0300);
        m_gnt = 1'b1;
        tick();
        m_gnt   = 1'b0;
        rst     = 1'b1;
        d_valid = 1'b0;
        tick();
        rst      = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'h5555_AAAA;
        chk("t6_m_req", m_req, 32'd0);
        chk("t6_m_addr", m_addr, 32'd0);
        chk("t6_m_wen", m_wen, 32'd0);
        chk("t6_m_wdata", m_wdata, 32'd0);
        chk("t6_m_wmask", m_wmask, 32'd0);
        chk("t6_d_ready", d_ready, 32'd0);
        chk("t6_d_rdata", d_rdata, 32'd0);
        chk("t6_err_clr", err_timeout, 32'd0);
        tick();
        m_rvalid = 1'b0;
        chk("t6_no_dready", d_ready, 32'd0);
        chk("t6_no_ipulse", i_rdata_valid, 32'd0);
        chk("t6_idle", m_req, 32'd0);
        last_d = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            do_txn(1'($urandom), 1'($urandom), int'($urandom_range(3, 0)),
                   int'($urandom_range(3, 0)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
